// File: rtl/exhaustive_equiv_checker.sv
// Sweeps all 2^N_IN input vectors through a circuit under test and a golden circuit and compares their outputs.
// Optional feature: define EQCHK_EARLY_EXIT_EN to end the sweep at the first mismatch.
module exhaustive_equiv_checker #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [N_IN-1:0] dut_in,
    input  logic            dut_out,
    input  logic            ref_out,
    output logic            busy,
    output logic            done,
    output logic            equiv,
    output logic [N_IN-1:0] cex,
    output logic [N_IN:0]   mism_cnt
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
    localparam logic [N_IN-1:0] LAST_VEC = '1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        CMP,
        DONE
    } state_t;

    // With no settle time the compare follows the vector edge directly.
    localparam state_t ENTRY_STATE = (SETTLE == 0) ? CMP : WAIT;

    state_t          state_reg, state_next;
    logic [N_IN-1:0] vec_reg, vec_next;
    logic [N_IN-1:0] cex_reg, cex_next;
    logic [N_IN:0]   mism_cnt_reg, mism_cnt_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic            busy_reg, busy_next;
    logic            done_reg, done_next;
    logic            equiv_reg, equiv_next;
    logic            mismatch;
    logic            last_vec;

    assign mismatch = dut_out ^ ref_out;

`ifdef EQCHK_EARLY_EXIT_EN
    assign last_vec = (vec_reg == LAST_VEC) || mismatch;
`else
    assign last_vec = (vec_reg == LAST_VEC);
`endif

    always_comb begin
        state_next    = state_reg;
        vec_next      = vec_reg;
        cex_next      = cex_reg;
        mism_cnt_next = mism_cnt_reg;
        cnt_next      = cnt_reg;
        busy_next     = busy_reg;
        done_next     = 1'b0;
        equiv_next    = equiv_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    vec_next      = '0;
                    cex_next      = '0;
                    mism_cnt_next = '0;
                    equiv_next    = 1'b1;
                    busy_next     = 1'b1;
                    cnt_next      = CW'(SETTLE);
                    state_next    = ENTRY_STATE;
                end
            end
            WAIT: begin
                cnt_next = cnt_reg - CW'(1);
                if (cnt_reg == CW'(1)) begin
                    state_next = CMP;
                end
            end
            CMP: begin
                if (mismatch) begin
                    mism_cnt_next = mism_cnt_reg + (N_IN + 1)'(1);
                    // equiv still high means nothing has failed yet in this sweep
                    if (equiv_reg) begin
                        cex_next   = vec_reg;
                        equiv_next = 1'b0;
                    end
                end
                if (last_vec) begin
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                    state_next = DONE;
                end else begin
                    vec_next   = vec_reg + N_IN'(1);
                    cnt_next   = CW'(SETTLE);
                    state_next = ENTRY_STATE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            vec_reg      <= '0;
            cex_reg      <= '0;
            mism_cnt_reg <= '0;
            cnt_reg      <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            equiv_reg    <= 1'b1;
        end else begin
            state_reg    <= state_next;
            vec_reg      <= vec_next;
            cex_reg      <= cex_next;
            mism_cnt_reg <= mism_cnt_next;
            cnt_reg      <= cnt_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            equiv_reg    <= equiv_next;
        end
    end

    assign dut_in   = vec_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign equiv    = equiv_reg;
    assign cex      = cex_reg;
    assign mism_cnt = mism_cnt_reg;

endmodule

// File: tb/tb_exhaustive_equiv_checker.sv
// Bench for exhaustive_equiv_checker: two instances (N_IN=2/SETTLE=1 and N_IN=3/SETTLE=0) driven from truth tables.
// Expectations come from a sweep model over the truth tables; honours EQCHK_EARLY_EXIT_EN.
module tb_exhaustive_equiv_checker;

`ifdef EQCHK_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    localparam logic [7:0] NAND2 = 8'b0000_0111;
    localparam logic [7:0] AND2  = 8'b0000_1000;
    localparam logic [7:0] NOR2  = 8'b0000_0001;
    localparam logic [7:0] NAND3 = 8'b0111_1111;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start_a = 1'b0, start_b = 1'b0;
    logic [3:0] tt_ad = '0, tt_ar = '0;
    logic [7:0] tt_bd = '0, tt_br = '0;

    logic [1:0] din_a, cex_a;
    logic [2:0] mc_a;
    logic       busy_a, done_a, equiv_a;
    logic [2:0] din_b, cex_b;
    logic [3:0] mc_b;
    logic       busy_b, done_b, equiv_b;

    exhaustive_equiv_checker #(.N_IN(2), .SETTLE(1)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .dut_in(din_a),
        .dut_out(tt_ad[din_a]), .ref_out(tt_ar[din_a]), .busy(busy_a),
        .done(done_a), .equiv(equiv_a), .cex(cex_a), .mism_cnt(mc_a)
    );

    exhaustive_equiv_checker #(.N_IN(3), .SETTLE(0)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .dut_in(din_b),
        .dut_out(tt_bd[din_b]), .ref_out(tt_br[din_b]), .busy(busy_b),
        .done(done_b), .equiv(equiv_b), .cex(cex_b), .mism_cnt(mc_b)
    );

    int         sel = 0;
    logic [2:0] cur_din, cur_cex;
    logic [3:0] cur_mc;
    logic       cur_busy, cur_done, cur_equiv;

    always_comb begin
        cur_din   = {1'b0, din_a};
        cur_cex   = {1'b0, cex_a};
        cur_mc    = {1'b0, mc_a};
        cur_busy  = busy_a;
        cur_done  = done_a;
        cur_equiv = equiv_a;
        if (sel != 0) begin
            cur_din   = din_b;
            cur_cex   = cex_b;
            cur_mc    = mc_b;
            cur_busy  = busy_b;
            cur_done  = done_b;
            cur_equiv = equiv_b;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input int which);
        sel = which;
        #1;
        check("rst_dut_in", 32'(cur_din), 0);
        check("rst_busy", 32'(cur_busy), 0);
        check("rst_done", 32'(cur_done), 0);
        check("rst_equiv", 32'(cur_equiv), 1);
        check("rst_cex", 32'(cur_cex), 0);
        check("rst_mism_cnt", 32'(cur_mc), 0);
    endtask

    // Model: sweep the truth tables, find first mismatch and count, derive latency.
    task automatic run_sweep(input int which, input logic [7:0] td, input logic [7:0] tr,
                             input bit poke_done);
        int n, s, nv, first, cnt, last_v, lat;
        n = (which == 0) ? 2 : 3;
        s = (which == 0) ? 1 : 0;
        nv = 1 << n;
        first = -1;
        cnt = 0;
        for (int v = 0; v < nv; v++) begin
            if (td[v] !== tr[v]) begin
                cnt++;
                if (first < 0) first = v;
                if (EARLY) break;
            end
        end
        last_v = (EARLY && first >= 0) ? first : nv - 1;
        lat = (last_v + 1) * (s + 1);

        sel = which;
        if (which == 0) begin
            tt_ad = td[3:0];
            tt_ar = tr[3:0];
        end else begin
            tt_bd = td;
            tt_br = tr;
        end

        @(negedge clk);
        if (which == 0) start_a = 1'b1; else start_b = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;

        for (int j = 0; j < lat; j++) begin
            @(negedge clk);
            check("sweep_busy", 32'(cur_busy), 1);
            check("sweep_done", 32'(cur_done), 0);
            check("sweep_dut_in", 32'(cur_din), 32'(j / (s + 1)));
        end

        @(negedge clk);
        check("end_done", 32'(cur_done), 1);
        check("end_busy", 32'(cur_busy), 0);
        check("end_dut_in", 32'(cur_din), 32'(last_v));
        check("end_equiv", 32'(cur_equiv), (first < 0) ? 1 : 0);
        check("end_cex", 32'(cur_cex), (first < 0) ? 0 : 32'(first));
        check("end_mism_cnt", 32'(cur_mc), 32'(cnt));
        if (poke_done) begin
            if (which == 0) start_a = 1'b1; else start_b = 1'b1;
        end

        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        check("post_done", 32'(cur_done), 0);
        check("post_busy", 32'(cur_busy), 0);
        check("post_dut_in", 32'(cur_din), 32'(last_v));
        check("post_equiv", 32'(cur_equiv), (first < 0) ? 1 : 0);
        check("post_cex", 32'(cur_cex), (first < 0) ? 0 : 32'(first));
        check("post_mism_cnt", 32'(cur_mc), 32'(cnt));

        $display("sweep inst=%0d td=%02h tr=%02h latency=%0d first=%0d count=%0d", which, td, tr, lat,
                 first, cnt);
    endtask

    initial begin
        logic [7:0] tr, mask;

        repeat (3) @(negedge clk);
        check_reset_vals(0);
        check_reset_vals(1);
        @(negedge clk);
        rst_n = 1'b1;

        run_sweep(0, NAND2, NAND2, 1'b0);
        run_sweep(0, AND2, NAND2, 1'b1);
        run_sweep(0, NOR2, NAND2, 1'b0);
        run_sweep(1, NAND3, NAND3, 1'b1);

        for (int i = 0; i < 4; i++) begin
            tr = 8'($urandom);
            mask = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
            run_sweep(1, tr ^ mask, tr, i[0]);
        end

        // Abort mid-sweep at vector 2, with a start attempt while busy.
        sel = 0;
        tt_ad = NAND2[3:0];
        tt_ar = NAND2[3:0];
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_vec2", 32'(cur_din), 2);
        check("abort_busy", 32'(cur_busy), 1);
        start_a = 1'b1;
        @(negedge clk);
        check("busy_start_ignored", 32'(cur_din), 2);
        check("busy_start_busy", 32'(cur_busy), 1);
        start_a = 1'b0;
        #2;
        rst_n = 1'b0;
        check_reset_vals(0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check("abort_no_done", 32'(cur_done), 0);
            check("abort_idle_busy", 32'(cur_busy), 0);
        end
        $display("abort inst=0 at vector 2, reset applied");
        run_sweep(0, NAND2, NAND2, 1'b0);

        for (int i = 0; i < 3; i++) begin
            tr = {4'h0, 4'($urandom)};
            mask = {4'h0, 4'($urandom)};
            run_sweep(0, tr ^ mask, tr, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/exhaustive_equiv_checker.md
# exhaustive_equiv_checker

Sequential equivalence checker for small combinational test circuits. It drives every input vector of an N-input circuit under test, samples the circuit output alongside a golden reference output, and reports whether they are equivalent. On a mismatch it also reports the first failing vector as a counterexample. It sits on the stimulus side of the gate-level test netlists and cross-checks SAT-solver equivalence verdicts in simulation.

## Interface
Parameters:
- N_IN, default 2: circuit input count; vector width; must be 1..16.
- SETTLE, default 1: wait cycles per vector before the compare; 0 allowed.

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a sweep; honoured only in IDLE
- dut_in  output  N_IN  current vector to both circuits; bit 0 is the vector LSB
- dut_out  input  1  output of the circuit under test
- ref_out  input  1  output of the golden circuit
- busy  output  1  sweep in progress
- done  output  1  one-cycle pulse at sweep end
- equiv  output  1  1 = no mismatch found in the last sweep
- cex  output  N_IN  first mismatching vector; 0 if none
- mism_cnt  output  N_IN+1  number of mismatching vectors

## Operation
- States: IDLE, WAIT, CMP, DONE.
- Reset (async, immediate): IDLE; dut_in=0, busy=0, done=0, equiv=1, cex=0, mism_cnt=0; internal vec=0, settle count=0.
- IDLE, start=1 at clock edge:
  - vec=0, dut_in=0, equiv=1, cex=0, mism_cnt=0, busy=1.
  - Go to WAIT with count=SETTLE, or straight to CMP if SETTLE=0.
- WAIT: decrement count each cycle; go to CMP after SETTLE cycles in WAIT.
- CMP: on its edge, compare dut_out against ref_out.
  - Mismatch: mism_cnt+1; if first mismatch, cex=vec and equiv=0.
  - If this was the last vector, go to DONE.
  - Otherwise vec+1, dut_in=vec+1, and enter WAIT (or CMP again if SETTLE=0).
- Last vector: vec = 2^N_IN−1, or the early-exit condition (see Configuration).
- DONE: done=1, busy=0 for exactly one cycle, then IDLE.
- Results stay stable until the next accepted start.
- dut_in is held at the final vector until the next start.
- start while busy or in DONE is ignored.
- vec never wraps; mism_cnt cannot overflow (its maximum is 2^N_IN).
- Reset mid-sweep aborts the sweep with no done pulse; all outputs return to reset values.

## Timing
- Start accepted at edge k. Vector v is driven from edge k+v·(SETTLE+1).
- Vector v is compared at edge k+(v+1)·(SETTLE+1).
- Full sweep: done is high in the cycle after edge k+2^N_IN·(SETTLE+1).
- Total latency from start to done = 2^N_IN·(SETTLE+1) edges.
- busy is high from edge k until the final compare edge.
- All outputs are registered; no combinational path from dut_out/ref_out to any output.

## Configuration
- EQCHK_EARLY_EXIT_EN defined: the first mismatch ends the sweep. That CMP goes to DONE, and mism_cnt is 1 when a mismatch occurs.
- EQCHK_EARLY_EXIT_EN undefined: every vector is always swept; mism_cnt counts all mismatches; cex holds the first.

## Test plan
- N_IN=2, SETTLE=1, DUT=NAND, ref=NAND, start at edge k -> done pulse after edge k+8; equiv=1, cex=0, mism_cnt=0.
- DUT=AND, ref=NAND, macro undefined -> equiv=0, cex=0, mism_cnt=4, done after edge k+8.
- Same DUT and ref, macro defined -> done after edge k+2; equiv=0, cex=0, mism_cnt=1.
- DUT=NOR, ref=NAND, macro undefined -> mismatches at vectors 1 and 2; cex=1, mism_cnt=2, equiv=0.
- SETTLE=0, DUT=NAND, ref=NAND -> dut_in steps 0,1,2,3 on consecutive edges; done after edge k+4.
- Reset mid-sweep at vector 2, plus start asserted while busy -> start is ignored; after reset, all outputs are at reset values, there is no done pulse, and a new start re-sweeps from vector 0.
